// File: rtl/key_pkg.sv
// Shared types for the key conditioner: channel FSM encoding, per-channel event bundle,
// and a width helper used for elaboration-time counter sizing checks.
package key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DEB_P   = 2'd1,
        ST_PRESSED = 2'd2,
        ST_DEB_R   = 2'd3
    } key_state_t;

    // 'release' is a language keyword, hence 'rel'
    typedef struct packed {
        logic level;
        logic press;
        logic rel;
        logic rpt;
    } key_evt_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchroniser, debounce FSM with a shared counter, registered
// press/release/auto-repeat pulses and debounced level.
module key_channel
    import key_pkg::*;
#(
    parameter int DEB_CYCLES    = 4,
    parameter int HOLD_CYCLES   = 50,
    parameter int REPEAT_CYCLES = 20,
    parameter int CNT_W         = 20
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     key_n,
    output key_evt_t evt
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic [1:0]       sync;
    logic             s;
    key_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             rpt_phase, rpt_phase_nxt;
    key_evt_t         evt_nxt;

    // Reset to "released" so a key held through reset is seen as a fresh press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], key_n};
    end

    assign s = ~sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rpt_phase <= 1'b0;
            evt       <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rpt_phase <= rpt_phase_nxt;
            evt       <= evt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        rpt_phase_nxt = rpt_phase;
        evt_nxt       = '0;
        case (state)
            ST_IDLE: begin
                if (s) begin
                    state_nxt = ST_DEB_P;
                    cnt_nxt   = '0;
                end
            end
            ST_DEB_P: begin
                if (!s) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt     = ST_PRESSED;
                    cnt_nxt       = '0;
                    rpt_phase_nxt = 1'b0;
                    evt_nxt.press = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                // A release edge wins over a repeat falling due on the same cycle
                if (!s) begin
                    state_nxt = ST_DEB_R;
                    cnt_nxt   = '0;
                end else if (cnt == (rpt_phase ? RPT_LAST : HOLD_LAST)) begin
                    evt_nxt.rpt   = 1'b1;
                    cnt_nxt       = '0;
                    rpt_phase_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_DEB_R: begin
                if (s) begin
                    state_nxt     = ST_PRESSED;
                    cnt_nxt       = '0;
                    rpt_phase_nxt = 1'b0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt   = ST_IDLE;
                    cnt_nxt     = '0;
                    evt_nxt.rel = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
        evt_nxt.level = (state_nxt == ST_PRESSED) || (state_nxt == ST_DEB_R);
    end

endmodule

// File: rtl/key_conditioner.sv
// Board key front-end: one independent key_channel per active-low KEY pin,
// outputs gathered into per-function vectors.
module key_conditioner
    import key_pkg::*;
#(
    parameter int N_KEYS        = 3,
    parameter int DEB_CYCLES    = 4,
    parameter int HOLD_CYCLES   = 50,
    parameter int REPEAT_CYCLES = 20,
    parameter int CNT_W         = 20
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic [N_KEYS-1:0] KEY_N,
    output logic [N_KEYS-1:0] level_o,
    output logic [N_KEYS-1:0] press_o,
    output logic [N_KEYS-1:0] release_o,
    output logic [N_KEYS-1:0] rpt_o
);

    localparam int MAX_DH  = (DEB_CYCLES > HOLD_CYCLES) ? DEB_CYCLES : HOLD_CYCLES;
    localparam int MAX_CYC = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;

    // Counters compare-and-reload below their terminal value, so this is the only sizing rule
    if (CNT_W < clog2(MAX_CYC + 1)) begin : g_cnt_w_check
        $error("key_conditioner: CNT_W too small for the configured cycle counts");
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_evt_t evt;

        key_channel #(
            .DEB_CYCLES   (DEB_CYCLES),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .CNT_W        (CNT_W)
        ) u_ch (
            .clk  (CLOCK_50),
            .rst  (rst),
            .key_n(KEY_N[i]),
            .evt  (evt)
        );

        assign level_o[i]   = evt.level;
        assign press_o[i]   = evt.press;
        assign release_o[i] = evt.rel;
        assign rpt_o[i]     = evt.rpt;
    end

endmodule
